// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared fp32 types and constants for the normalize/round pipeline
package fp_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    localparam int EXP_MAX = 255;
    localparam int MANT_W  = 23;
    localparam int GRS_W   = 3;
    localparam int LZ_ZERO = 27;

    localparam int SIG_W = MANT_W + 1 + GRS_W;
    localparam int EXP_W = 10;

endpackage

// File: rtl/fp_round.sv
// rtl/fp_round.sv - round-to-nearest-even and pack of a normalized 27-bit significand
module fp_round
    import fp_pkg::*;
(
    input  logic                    sign,
    input  logic [SIG_W-1:0]        sig,
    input  logic signed [EXP_W-1:0] exp,
    output fp32_t                   result,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    inexact
);

    localparam logic signed [EXP_W-1:0] EXP_INF = EXP_W'(EXP_MAX);

    logic                    round_up;
    logic [MANT_W+1:0]       sum;
    logic signed [EXP_W-1:0] exp_r;

    assign round_up = sig[2] & (sig[1] | sig[0] | sig[3]);
    assign sum      = {1'b0, sig[SIG_W-1:GRS_W]} + {{MANT_W+1{1'b0}}, round_up};
    // a carry out of the 24-bit significand leaves sum[22:0] all zero
    assign exp_r    = exp + $signed({{EXP_W-1{1'b0}}, sum[MANT_W+1]});

    always_comb begin
        result    = '0;
        overflow  = 1'b0;
        underflow = 1'b0;
        inexact   = 1'b0;
        if (sig == '0) begin
            result = '0;
        end else if (exp[EXP_W-1] || exp == '0) begin
            result.sign = sign;
            underflow   = 1'b1;
            inexact     = 1'b1;
        end else if (exp_r >= EXP_INF) begin
            result.sign = sign;
            result.exp  = 8'hFF;
            overflow    = 1'b1;
            inexact     = 1'b1;
        end else begin
            result.sign = sign;
            result.exp  = exp_r[7:0];
            result.frac = sum[MANT_W-1:0];
            inexact     = |sig[GRS_W-1:0];
        end
    end

endmodule

// File: rtl/fp_normalize_round.sv
// rtl/fp_normalize_round.sv - two-stage valid/ready normalize (S1) and round/pack (S2) pipeline
module fp_normalize_round
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [26:0] in_mant,
    input  logic        in_carry,
    input  logic [4:0]  in_shift,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_overflow,
    output logic        out_underflow,
    output logic        out_inexact
);

    logic                    s1_valid;
    logic                    s1_sign;
    logic [SIG_W-1:0]        s1_sig;
    logic signed [EXP_W-1:0] s1_exp;

    logic                    s2_en;
    logic [SIG_W-1:0]        norm_sig;
    logic signed [EXP_W-1:0] norm_exp;

    fp32_t rnd_result;
    logic  rnd_overflow;
    logic  rnd_underflow;
    logic  rnd_inexact;

    assign s2_en    = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_en;

    // zero and flush-to-zero cases fall out of the shifted significand / exponent sign in fp_round
    always_comb begin
        norm_sig = '0;
        norm_exp = '0;
        if (in_carry) begin
            norm_sig = {1'b1, in_mant[26:2], in_mant[1] | in_mant[0]};
            norm_exp = $signed({2'b00, in_exp}) + 10'sd1;
        end else begin
            norm_sig = (in_shift >= 5'(LZ_ZERO)) ? '0 : (in_mant << in_shift);
            norm_exp = $signed({2'b00, in_exp}) - $signed({5'b00000, in_shift});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_sig   <= '0;
            s1_exp   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= in_sign;
                s1_sig  <= norm_sig;
                s1_exp  <= norm_exp;
            end
        end
    end

    fp_round u_round (
        .sign      (s1_sign),
        .sig       (s1_sig),
        .exp       (s1_exp),
        .result    (rnd_result),
        .overflow  (rnd_overflow),
        .underflow (rnd_underflow),
        .inexact   (rnd_inexact)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result    <= rnd_result;
                out_overflow  <= rnd_overflow;
                out_underflow <= rnd_underflow;
                out_inexact   <= rnd_inexact;
            end
        end
    end

endmodule

// File: tb/tb_fp_normalize_round.sv
// tb/tb_fp_normalize_round.sv - directed scoreboard bench for fp_normalize_round
module tb_fp_normalize_round;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [26:0] in_mant;
    logic        in_carry;
    logic [4:0]  in_shift;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    int errors = 0;
    int checks = 0;
    logic [34:0] exp_q[$];

    always #5 clk = ~clk;

    fp_normalize_round dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_mant       (in_mant),
        .in_carry      (in_carry),
        .in_shift      (in_shift),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_inexact   (out_inexact)
    );

    task automatic check(input string tag, input logic [34:0] got, input logic [34:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, want);
        end
    endtask

    // want = {result[31:0], overflow, underflow, inexact}
    task automatic drive(input logic s, input logic [7:0] e, input logic [26:0] m,
                         input logic c, input logic [4:0] sh, input logic [34:0] want);
        int n = 0;
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        in_carry = c;
        in_shift = sh;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (in_ready === 1'b1) else begin
            errors++;
            $error("FAIL accept_timeout got=%b exp=1", in_ready);
        end
        exp_q.push_back(want);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL drain_timeout got=%0d exp=0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [34:0] got;
        logic [34:0] want;
        logic [34:0] held_v;
        logic        held;
        held   = 1'b0;
        held_v = '0;
        forever begin
            @(negedge clk);
            got = {out_result, out_overflow, out_underflow, out_inexact};
            if (rst_n && out_valid && !out_ready) begin
                if (held) begin
                    checks++;
                    assert (got === held_v) else begin
                        errors++;
                        $error("FAIL stall_hold got=%h exp=%h", got, held_v);
                    end
                end
                held   = 1'b1;
                held_v = got;
            end else begin
                held = 1'b0;
            end
            if (rst_n && out_valid && out_ready) begin
                checks++;
                assert (exp_q.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_output got=%h exp=none", got);
                end
                if (exp_q.size() > 0) begin
                    want = exp_q.pop_front();
                    checks++;
                    assert (got === want) else begin
                        errors++;
                        $error("FAIL result got=%h exp=%h", got, want);
                    end
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = 8'h00;
        in_mant   = '0;
        in_carry  = 1'b0;
        in_shift  = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", {34'b0, out_valid}, 35'd0);
        check("reset_out_word", {out_result, out_overflow, out_underflow, out_inexact}, 35'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_in_ready", {34'b0, in_ready}, 35'd1);

        drive(1'b1, 8'h80, 27'h0000000, 1'b0, 5'd27, {32'h00000000, 3'b000});
        in_valid = 1'b0;
        check("latency_cycle1", {34'b0, out_valid}, 35'd0);
        @(posedge clk);
        #1;
        check("latency_cycle2", {34'b0, out_valid}, 35'd1);
        wait_drain();

        drive(1'b0, 8'h85, 27'h0400000, 1'b0, 5'd4,  {32'h40800000, 3'b000});
        drive(1'b0, 8'h7F, 27'h400000C, 1'b0, 5'd0,  {32'h3F800002, 3'b001});
        drive(1'b0, 8'h7F, 27'h4000004, 1'b0, 5'd0,  {32'h3F800000, 3'b001});
        drive(1'b0, 8'hFE, 27'h7FFFFFF, 1'b0, 5'd0,  {32'h7F800000, 3'b101});
        drive(1'b0, 8'h7F, 27'h4000000, 1'b1, 5'd0,  {32'h40400000, 3'b000});
        drive(1'b1, 8'h7F, 27'h4000001, 1'b1, 5'd0,  {32'hC0400000, 3'b001});
        drive(1'b1, 8'hFE, 27'h0000000, 1'b1, 5'd0,  {32'hFF800000, 3'b101});
        drive(1'b0, 8'h7F, 27'h7FFFFFC, 1'b0, 5'd0,  {32'h40000000, 3'b001});
        drive(1'b1, 8'h10, 27'h0000100, 1'b0, 5'd18, {32'h80000000, 3'b011});
        drive(1'b0, 8'h05, 27'h0400000, 1'b0, 5'd4,  {32'h00800000, 3'b000});
        drive(1'b0, 8'h04, 27'h0400000, 1'b0, 5'd4,  {32'h00000000, 3'b011});
        drive(1'b1, 8'h01, 27'h0000000, 1'b0, 5'd27, {32'h00000000, 3'b000});
        in_valid = 1'b0;
        wait_drain();

        out_ready = 1'b0;
        drive(1'b0, 8'h85, 27'h0400000, 1'b0, 5'd4, {32'h40800000, 3'b000});
        drive(1'b0, 8'h7F, 27'h400000C, 1'b0, 5'd0, {32'h3F800002, 3'b001});
        fork
            begin
                drive(1'b0, 8'h7F, 27'h4000004, 1'b0, 5'd0, {32'h3F800000, 3'b001});
                in_valid = 1'b0;
            end
            begin
                check("bp_in_ready_low", {34'b0, in_ready}, 35'd0);
                check("bp_out_valid", {34'b0, out_valid}, 35'd1);
                repeat (5) @(posedge clk);
                #1;
                check("bp_in_ready_still_low", {34'b0, in_ready}, 35'd0);
                out_ready = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check("bp_no_gap", {34'b0, out_valid}, 35'd1);
                end
            end
        join
        wait_drain();

        drive(1'b0, 8'h85, 27'h0400000, 1'b0, 5'd4, {32'h40800000, 3'b000});
        drive(1'b1, 8'h7F, 27'h4000004, 1'b0, 5'd0, {32'hBF800000, 3'b001});
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", {34'b0, out_valid}, 35'd0);
        check("rst_out_word", {out_result, out_overflow, out_underflow, out_inexact}, 35'd0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_release_in_ready", {34'b0, in_ready}, 35'd1);
        repeat (4) begin
            @(negedge clk);
            check("rst_no_stale", {34'b0, out_valid}, 35'd0);
        end
        @(posedge clk);
        #1;
        drive(1'b0, 8'h7F, 27'h400000C, 1'b0, 5'd0, {32'h3F800002, 3'b001});
        in_valid = 1'b0;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
